// File: rtl/gpmc_mem_arbiter_pkg.sv
// Shared definitions for the GPMC/local RAM arbiter: default geometry,
// host-op encoding, read-return tag and the round-robin pointer step.
package gpmc_mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int MAX_REQ        = 8;
    localparam int IDX_WIDTH      = $clog2(MAX_REQ);

    typedef enum logic {
        HOST_OP_READ  = 1'b0,
        HOST_OP_WRITE = 1'b1
    } host_op_e;

    typedef struct packed {
        logic                 host;
        logic [IDX_WIDTH-1:0] idx;
    } rd_tag_t;

    function automatic logic [IDX_WIDTH-1:0] rr_next(input logic [IDX_WIDTH-1:0] idx,
                                                     input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + IDX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/gpmc_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping back to bit 0.
module rr_arbiter
    import gpmc_mem_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 any
);

    logic found;

    // Two passes: upper segment [ptr..N-1] first, then the wrapped [0..ptr-1].
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IDX_WIDTH'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/gpmc_mem_arbiter.sv
// Shares one single-port RAM between the ARM host (via gpmc_sync, fixed
// priority) and N_REQ local requesters served round-robin.
module gpmc_mem_arbiter
    import gpmc_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        host_csn,
    input  logic                        host_wen,
    input  logic                        host_oen,
    input  logic [ADDR_WIDTH-1:0]       host_addr,
    input  logic [DATA_WIDTH-1:0]       host_wdata,
    output logic [DATA_WIDTH-1:0]       host_rdata,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    logic                  host_wr;
    logic                  host_rd;
    logic                  host_wr_q;
    logic                  host_rd_q;
    logic                  host_edge;
    logic                  host_pend;
    host_op_e              host_op;
    logic [ADDR_WIDTH-1:0] host_addr_q;
    logic [DATA_WIDTH-1:0] host_wdata_q;

    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic [N_REQ-1:0]      arb_onehot;
    logic [IDX_WIDTH-1:0]  arb_idx;
    logic                  arb_any;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rd_tag_t               iss_tag;
    rd_tag_t               rd1_tag;
    logic                  rd1_valid;

    assign host_wr   = ~host_csn & ~host_wen &  host_oen;
    assign host_rd   = ~host_csn &  host_wen & ~host_oen;
    assign host_edge = (host_wr & ~host_wr_q) | (host_rd & ~host_rd_q);

    // Only strobe edges count, so a held strobe produces a single access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_wr_q    <= 1'b0;
            host_rd_q    <= 1'b0;
            host_pend    <= 1'b0;
            host_op      <= HOST_OP_READ;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
        end else begin
            host_wr_q <= host_wr;
            host_rd_q <= host_rd;
            if (host_edge) begin
                host_pend    <= 1'b1;
                host_op      <= host_wr ? HOST_OP_WRITE : HOST_OP_READ;
                host_addr_q  <= host_addr;
                host_wdata_q <= host_wdata;
            end else if (host_pend) begin
                host_pend <= 1'b0;
            end
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_onehot[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Idle cycles keep the last address/data on the RAM bus to avoid toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            gnt       <= '0;
            iss_tag   <= '0;
            rr_ptr    <= '0;
        end else if (host_pend) begin
            mem_en       <= 1'b1;
            mem_we       <= (host_op == HOST_OP_WRITE);
            mem_addr     <= host_addr_q;
            mem_wdata    <= host_wdata_q;
            gnt          <= '0;
            iss_tag.host <= 1'b1;
            iss_tag.idx  <= '0;
        end else if (arb_any) begin
            mem_en       <= 1'b1;
            mem_we       <= sel_we;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            gnt          <= arb_onehot;
            iss_tag.host <= 1'b0;
            iss_tag.idx  <= arb_idx;
            rr_ptr       <= rr_next(arb_idx, N_REQ);
        end else begin
            mem_en <= 1'b0;
            gnt    <= '0;
        end
    end

    // RAM answers one cycle after mem_en; the tag rides one stage behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_valid  <= 1'b0;
            rd1_tag    <= '0;
            rd_valid   <= '0;
            rdata      <= '0;
            host_rdata <= '0;
        end else begin
            rd1_valid <= mem_en & ~mem_we;
            rd1_tag   <= iss_tag;
            rd_valid  <= '0;
            if (rd1_valid) begin
                if (rd1_tag.host) begin
                    host_rdata <= mem_rdata;
                end else begin
                    rdata    <= mem_rdata;
                    rd_valid <= N_REQ'(1) << rd1_tag.idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpmc_mem_arbiter.sv
// Scoreboard bench for gpmc_mem_arbiter: expected RAM accesses and read
// returns are queued as stimulus is driven and checked as the DUT acts.
module tb_gpmc_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           host_csn = 1'b1;
    logic           host_wen = 1'b1;
    logic           host_oen = 1'b1;
    logic [AW-1:0]  host_addr = '0;
    logic [DW-1:0]  host_wdata = '0;
    logic [DW-1:0]  host_rdata;
    logic [NR-1:0]  req = '0;
    logic [NR-1:0]  req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  rd_valid;
    logic [DW-1:0]  rdata;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata = '0;

    typedef struct packed {
        logic          valid;
        logic          host;
        logic [NR-1:0] gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rexp;
    } acc_t;

    acc_t          exp_q[$];
    acc_t          s1, s2, cur, mon_e;
    logic [DW-1:0] shadow [2**AW];
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] host_hold;
    logic [DW-1:0] rdata_hold;
    logic [NR-1:0] exp_rdv;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    gpmc_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_csn   (host_csn),
        .host_wen   (host_wen),
        .host_oen   (host_oen),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rd_valid   (rd_valid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // External single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_access(input logic host, input int idx, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        acc_t e;
        e.valid = 1'b1;
        e.host  = host;
        e.gnt   = host ? '0 : (NR'(1) << idx);
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        if (we) shadow[addr] = wdata;
        e.rexp  = shadow[addr];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        push_access(1'b1, 0, we, addr, wdata);
        host_csn = 1'b0; host_wen = ~we; host_oen = we;
        host_addr = addr; host_wdata = wdata;
        idle(4);
        host_csn = 1'b1; host_wen = 1'b1; host_oen = 1'b1;
        idle(1);
    endtask

    task automatic local_burst(input int idx, input logic we, input logic [AW-1:0] base,
                               input int count, input logic [DW-1:0] dbase);
        for (int k = 0; k < count; k++) begin
            int            waited;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = base + AW'(k);
            d = dbase + DW'(k);
            push_access(1'b0, idx, we, a, d);
            req_we[idx] = we;
            req_addr[idx*AW +: AW] = a;
            req_wdata[idx*DW +: DW] = d;
            req[idx] = 1'b1;
            waited = 0;
            do begin
                @(posedge clk); #1;
                waited++;
            end while (!gnt[idx] && waited < 20);
            check_output("burst_gnt_latency", waited, 1);
        end
        req[idx] = 1'b0;
    endtask

    task automatic check_zero(input string pfx);
        check_output({pfx, "_mem_en"},     mem_en, 0);
        check_output({pfx, "_mem_we"},     mem_we, 0);
        check_output({pfx, "_mem_addr"},   mem_addr, 0);
        check_output({pfx, "_mem_wdata"},  mem_wdata, 0);
        check_output({pfx, "_gnt"},        gnt, 0);
        check_output({pfx, "_rd_valid"},   rd_valid, 0);
        check_output({pfx, "_rdata"},      rdata, 0);
        check_output({pfx, "_host_rdata"}, host_rdata, 0);
    endtask

    // Pops one expected access per mem_en and checks read returns two cycles later.
    always @(negedge clk) begin
        if (rst) begin
            s1 = '0; s2 = '0;
            host_hold = '0; rdata_hold = '0;
        end else begin
            cur = '0;
            check_output("gnt_onehot0", 32'($onehot0(gnt)), 1);
            check_output("rd_valid_onehot0", 32'($onehot0(rd_valid)), 1);
            if (mem_en) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_access", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("acc_we",   mem_we, mon_e.we);
                    check_output("acc_addr", mem_addr, mon_e.addr);
                    check_output("acc_gnt",  gnt, mon_e.gnt);
                    if (mon_e.we) check_output("acc_wdata", mem_wdata, mon_e.wdata);
                    cur = mon_e;
                    cur.valid = ~mon_e.we;
                end
            end else begin
                check_output("gnt_without_en", gnt, 0);
            end
            exp_rdv = (s2.valid && !s2.host) ? s2.gnt : '0;
            check_output("rd_valid", rd_valid, exp_rdv);
            if (s2.valid) begin
                if (s2.host) host_hold = s2.rexp;
                else         rdata_hold = s2.rexp;
            end
            check_output("host_rdata", host_rdata, host_hold);
            check_output("rdata", rdata, rdata_hold);
            s2 = s1;
            s1 = cur;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Host write then read back the same word.
        host_access(1'b1, 5'd3, 16'h00A5);
        host_access(1'b0, 5'd3, 16'h0000);
        idle(3);

        // Both requesters held for four cycles alternate 0,1,0,1.
        push_access(1'b0, 0, 1'b1, 5'd10, 16'h1111);
        push_access(1'b0, 1, 1'b1, 5'd11, 16'h2222);
        push_access(1'b0, 0, 1'b1, 5'd10, 16'h1111);
        push_access(1'b0, 1, 1'b1, 5'd11, 16'h2222);
        req_we = 2'b11;
        req_addr = {5'd11, 5'd10};
        req_wdata = {16'h2222, 16'h1111};
        req = 2'b11;
        idle(4);
        req = 2'b00;
        idle(2);

        // Local read arrives while the host write is pending: host goes first.
        push_access(1'b1, 0, 1'b1, 5'd7, 16'h1234);
        host_csn = 1'b0; host_wen = 1'b0; host_oen = 1'b1;
        host_addr = 5'd7; host_wdata = 16'h1234;
        idle(1);
        push_access(1'b0, 0, 1'b0, 5'd7, 16'h0000);
        req_we[0] = 1'b0; req_addr[0 +: AW] = 5'd7; req[0] = 1'b1;
        idle(1);
        check_output("collide_host_first", gnt, 0);
        idle(1);
        check_output("collide_gnt0_next", gnt, 2'b01);
        req[0] = 1'b0;
        idle(2);
        host_csn = 1'b1; host_wen = 1'b1; host_oen = 1'b1;
        idle(3);

        // Back-to-back local writes then reads on requester 1.
        local_burst(1, 1'b1, 5'd0, 4, 16'h0100);
        local_burst(1, 1'b0, 5'd0, 4, 16'h0000);
        idle(3);

        // Requester 0 pulses a write for one cycle while host_pend is set.
        push_access(1'b1, 0, 1'b0, 5'd20, 16'h0000);
        host_csn = 1'b0; host_wen = 1'b1; host_oen = 1'b0; host_addr = 5'd20;
        idle(1);
        req_we[0] = 1'b1; req_addr[0 +: AW] = 5'd20; req_wdata[0 +: DW] = 16'hDEAD;
        req[0] = 1'b1;
        idle(1);
        req[0] = 1'b0;
        check_output("withdraw_no_gnt", gnt, 0);
        idle(2);
        host_csn = 1'b1; host_wen = 1'b1; host_oen = 1'b1;
        idle(3);
        host_access(1'b0, 5'd20, 16'h0000);
        idle(4);

        // Reset lands while a local read is in flight.
        push_access(1'b0, 1, 1'b0, 5'd2, 16'h0000);
        req_we[1] = 1'b0; req_addr[AW +: AW] = 5'd2; req[1] = 1'b1;
        idle(1);
        check_output("midread_gnt", gnt, 2'b10);
        req[1] = 1'b0;
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midread_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);

        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
